// File: rtl/alu_shift_sequencer.sv
// Multi-bit shift controller: drives the single-position ALU shift unit once per requested position.
// Optional build macro SHIFT_SEQ_EARLY_EXIT_EN: finish as soon as the working value becomes zero.
module alu_shift_sequencer #(
  parameter int unsigned Op_Width  = 16,
  parameter int unsigned Cnt_Width = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [Op_Width-1:0]  req_data,
  input  logic [Cnt_Width-1:0] req_amt,
  input  logic                 req_dir,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [Op_Width-1:0]  resp_data,
  output logic                 resp_err,
  output logic [Op_Width-1:0]  su_A,
  output logic [Op_Width-1:0]  su_B,
  output logic [1:0]           su_ALU_FUN,
  output logic                 su_Shift_En,
  input  logic [Op_Width-1:0]  su_Shift_Out,
  input  logic                 su_Shift_Flag
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]           state, state_nxt;
  logic [Op_Width-1:0]  cur, cur_nxt;
  logic [Cnt_Width-1:0] cnt, cnt_nxt;
  logic                 dir, dir_nxt;
  logic                 err, err_nxt;
  logic                 early_exit_c;

`ifdef SHIFT_SEQ_EARLY_EXIT_EN
  // A zero working value cannot change under further logical shifts.
  assign early_exit_c = (su_Shift_Out == '0);
`else
  assign early_exit_c = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      cur   <= '0;
      cnt   <= '0;
      dir   <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cur   <= cur_nxt;
      cnt   <= cnt_nxt;
      dir   <= dir_nxt;
      err   <= err_nxt;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    cnt_nxt   = cnt;
    dir_nxt   = dir;
    err_nxt   = err;
    case (state)
      IDLE: begin
        if (req_valid) begin
          cur_nxt   = req_data;
          cnt_nxt   = req_amt;
          dir_nxt   = req_dir;
          err_nxt   = 1'b0;
          state_nxt = (req_amt == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (su_Shift_Flag) begin
          cur_nxt   = su_Shift_Out;
          cnt_nxt   = cnt - Cnt_Width'(1);
          state_nxt = ((cnt == Cnt_Width'(1)) || early_exit_c) ? DONE : ISSUE;
        end else begin
          err_nxt   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode straight from the registered state so reset clears them asynchronously.
  assign req_ready   = (state == IDLE);
  assign resp_valid  = (state == DONE);
  assign resp_data   = cur;
  assign resp_err    = (state == DONE) & err;
  assign su_A        = cur;
  assign su_B        = '0;
  assign su_ALU_FUN  = {1'b0, dir};
  assign su_Shift_En = (state == ISSUE);

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Directed bench for alu_shift_sequencer with a behavioural single-step shift unit.
module tb_alu_shift_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid, req_ready, req_dir;
  logic [15:0] req_data;
  logic [3:0]  req_amt;
  logic        resp_valid, resp_ready, resp_err;
  logic [15:0] resp_data, su_A, su_B, su_Shift_Out;
  logic [1:0]  su_ALU_FUN;
  logic        su_Shift_En, su_Shift_Flag;

  int total = 0;
  int bad   = 0;

  int pulses;
  int fun_bad;
  int b2b_bad;
  int step_idx;
  int err_step;
  logic [1:0] exp_fun;
  logic prev_en;

  always #5 CLK = ~CLK;

  alu_shift_sequencer dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_amt(req_amt), .req_dir(req_dir),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_err(resp_err),
    .su_A(su_A), .su_B(su_B), .su_ALU_FUN(su_ALU_FUN), .su_Shift_En(su_Shift_En),
    .su_Shift_Out(su_Shift_Out), .su_Shift_Flag(su_Shift_Flag)
  );

  // Shift unit model: registered single-bit logical shift, flag can be forced low on one step.
  always @(posedge CLK or negedge (~RST)) begin
    if (RST) begin
      su_Shift_Out  <= 16'h0;
      su_Shift_Flag <= 1'b0;
    end else begin
      su_Shift_Flag <= su_Shift_En && (step_idx + 1 != err_step);
      if (su_Shift_En)
        su_Shift_Out <= su_ALU_FUN[0] ? {su_A[14:0], 1'b0} : {1'b0, su_A[15:1]};
    end
  end

  // Pulse monitor.
  always @(posedge CLK) begin
    if (su_Shift_En) begin
      pulses   <= pulses + 1;
      step_idx <= step_idx + 1;
      if (su_ALU_FUN != exp_fun) fun_bad <= fun_bad + 1;
      if (prev_en) b2b_bad <= b2b_bad + 1;
    end
    prev_en <= su_Shift_En;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request, measure latency, hold the response, then complete the handshake.
  task automatic run_req(input string tag, input logic [15:0] data, input logic [3:0] amt,
                         input logic dir, input int estep, input logic [15:0] exp_data,
                         input logic exp_err, input int exp_lat, input int exp_pulses,
                         input int hold);
    int n;
    logic [15:0] first_data;
    @(negedge CLK);
    pulses = 0; fun_bad = 0; b2b_bad = 0; step_idx = 0;
    err_step = estep;
    exp_fun = {1'b0, dir};
    req_valid = 1'b1; req_data = data; req_amt = amt; req_dir = dir;
    @(posedge CLK);
    #1 req_valid = 1'b0;
    n = 0;
    if (resp_valid) n = 1;
    else begin
      while (!resp_valid && n < 40) begin
        @(posedge CLK); #1 n++;
      end
    end
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check({tag, "_data"}, 32'(resp_data), 32'(exp_data));
    check({tag, "_err"}, 32'(resp_err), 32'(exp_err));
    first_data = resp_data;
    for (int i = 0; i < hold; i++) begin
      @(posedge CLK); #1;
      check({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
      check({tag, "_hold_data"}, 32'(resp_data), 32'(first_data));
      check({tag, "_hold_rdy"}, 32'(req_ready), 32'd0);
    end
    @(negedge CLK) resp_ready = 1'b1;
    @(posedge CLK);
    #1 resp_ready = 1'b0;
    check({tag, "_rdy_after"}, 32'(req_ready), 32'd1);
    check({tag, "_pulses"}, 32'(pulses), 32'(exp_pulses));
    check({tag, "_fun"}, 32'(fun_bad), 32'd0);
    check({tag, "_b2b"}, 32'(b2b_bad), 32'd0);
    err_step = 0;
  endtask

  initial begin
    RST = 1'b1;
    req_valid = 1'b0; req_data = 16'h0; req_amt = 4'h0; req_dir = 1'b0;
    resp_ready = 1'b0;
    pulses = 0; fun_bad = 0; b2b_bad = 0; step_idx = 0; err_step = 0;
    exp_fun = 2'b00; prev_en = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", 32'(resp_data), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_en", 32'(su_Shift_En), 32'd0);
    check("rst_su_a", 32'(su_A), 32'd0);
    check("rst_su_b", 32'(su_B), 32'd0);
    check("rst_fun", 32'(su_ALU_FUN), 32'd0);
    @(negedge CLK) RST = 1'b0;

    run_req("r8000_4", 16'h8000, 4'd4, 1'b0, 0, 16'h0800, 1'b0, 8, 4, 0);
    run_req("l0001_15", 16'h0001, 4'd15, 1'b1, 0, 16'h8000, 1'b0, 30, 15, 0);
    run_req("amt0", 16'h1234, 4'd0, 1'b0, 0, 16'h1234, 1'b0, 1, 0, 5);
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
    run_req("l4000_8", 16'h4000, 4'd8, 1'b1, 0, 16'h0000, 1'b0, 4, 2, 0);
`else
    run_req("l4000_8", 16'h4000, 4'd8, 1'b1, 0, 16'h0000, 1'b0, 16, 8, 0);
`endif
    run_req("err_step2", 16'h00F0, 4'd3, 1'b0, 2, 16'h0078, 1'b1, 4, 2, 0);

    // Reset while waiting on the shift unit.
    @(negedge CLK);
    req_valid = 1'b1; req_data = 16'h0001; req_amt = 4'd10; req_dir = 1'b1; exp_fun = 2'b01;
    @(posedge CLK);
    #1 req_valid = 1'b0;
    @(posedge CLK);
    #2;
    check("mid_en_before", 32'(su_Shift_En), 32'd0);
    check("mid_busy", 32'(req_ready), 32'd0);
    RST = 1'b1;
    #1;
    check("rst_mid_en", 32'(su_Shift_En), 32'd0);
    check("rst_mid_valid", 32'(resp_valid), 32'd0);
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    @(negedge CLK) RST = 1'b0;
    run_req("post_rst", 16'h0004, 4'd2, 1'b0, 0, 16'h0001, 1'b0, 4, 2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
